// File: rtl/alu_result_checker.sv
// -----------------------------------------------------------------------------
// alu_result_checker
//
// Response checker for an ALU under test. Observed transactions (opcode,
// operands, observed result) arrive over a valid/ready handshake, pass through
// a two-stage pipeline that recomputes the golden result, and are scored into
// saturating pass/fail counters. The first mismatch is captured and can
// optionally halt intake until clear or reset.
//
// Pipeline: accept edge N loads S1; edge N+1 loads S2 with the golden value
// and compare result; edge N+2 updates counters, err_flag, ff_* and FSM.
//
// Optional feature macro: ALU_CHK_LOG_EN adds a 4-entry mismatch log FIFO
// (log_rd, log_empty, log_ovf, log_opcode, log_expected, log_actual).
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   obs_valid / obs_ready    observed transaction handshake
//   obs_opcode/in1/in2/out   observed transaction fields
//   stop_on_fail             halt intake on first mismatch
//   clear                    synchronous clear of counters/capture/state
//   pass_cnt, fail_cnt       saturating match / mismatch counters
//   err_flag                 sticky mismatch indicator
//   halted                   high in HALT state
//   ff_opcode/expected/actual first-fail capture
// -----------------------------------------------------------------------------
module alu_result_checker #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              obs_valid,
  output logic              obs_ready,
  input  logic [2:0]        obs_opcode,
  input  logic [DATA_W-1:0] obs_in1,
  input  logic [DATA_W-1:0] obs_in2,
  input  logic [DATA_W-1:0] obs_out,
  input  logic              stop_on_fail,
  input  logic              clear,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err_flag,
  output logic              halted,
  output logic [2:0]        ff_opcode,
  output logic [DATA_W-1:0] ff_expected,
  output logic [DATA_W-1:0] ff_actual
`ifdef ALU_CHK_LOG_EN
  ,
  input  logic              log_rd,
  output logic              log_empty,
  output logic              log_ovf,
  output logic [2:0]        log_opcode,
  output logic [DATA_W-1:0] log_expected,
  output logic [DATA_W-1:0] log_actual
`endif
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]        r_state;
  logic              r_rst_done;   // holds obs_ready low until the first edge after reset

  logic              r_s1_valid;
  logic [2:0]        r_s1_opcode;
  logic [DATA_W-1:0] r_s1_in1, r_s1_in2, r_s1_out;

  logic              r_s2_valid, r_s2_match;
  logic [2:0]        r_s2_opcode;
  logic [DATA_W-1:0] r_s2_expected, r_s2_actual;

  logic [CNT_W-1:0]  r_pass_cnt, r_fail_cnt;
  logic              r_err_flag;
  logic [2:0]        r_ff_opcode;
  logic [DATA_W-1:0] r_ff_expected, r_ff_actual;

  logic              w_accept;
  logic [DATA_W-1:0] w_golden;
  logic              w_s2_fail;

  assign obs_ready = r_rst_done && (r_state == ST_RUN) && !clear;
  assign w_accept  = obs_valid && obs_ready;
  assign w_s2_fail = r_s2_valid && !r_s2_match;

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_golden = '0;
    case (r_s1_opcode)
      3'b000:  w_golden = r_s1_in1 + r_s1_in2;
      3'b001:  w_golden = r_s1_in1 - r_s1_in2;
      3'b010:  w_golden = ~r_s1_in1;
      3'b011:  w_golden = r_s1_in1 & r_s1_in2;
      3'b100:  w_golden = r_s1_in1 | r_s1_in2;
      3'b101:  w_golden = r_s1_in1 ^ r_s1_in2;
      3'b110:  w_golden = {r_s1_in1[DATA_W-2:0], 1'b0};
      default: w_golden = {1'b0, r_s1_in1[DATA_W-1:1]};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done    <= 1'b0;
      r_state       <= ST_RUN;
      r_s1_valid    <= 1'b0;
      r_s1_opcode   <= '0;
      r_s1_in1      <= '0;
      r_s1_in2      <= '0;
      r_s1_out      <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_match    <= 1'b0;
      r_s2_opcode   <= '0;
      r_s2_expected <= '0;
      r_s2_actual   <= '0;
      r_pass_cnt    <= '0;
      r_fail_cnt    <= '0;
      r_err_flag    <= 1'b0;
      r_ff_opcode   <= '0;
      r_ff_expected <= '0;
      r_ff_actual   <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (clear) begin
        // Flush in-flight entries without scoring them.
        r_state       <= ST_RUN;
        r_s1_valid    <= 1'b0;
        r_s2_valid    <= 1'b0;
        r_pass_cnt    <= '0;
        r_fail_cnt    <= '0;
        r_err_flag    <= 1'b0;
        r_ff_opcode   <= '0;
        r_ff_expected <= '0;
        r_ff_actual   <= '0;
      end else begin
        // S1: capture accepted fields.
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_opcode <= obs_opcode;
          r_s1_in1    <= obs_in1;
          r_s1_in2    <= obs_in2;
          r_s1_out    <= obs_out;
        end
        // S2: golden value and compare result.
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_match    <= (w_golden == r_s1_out);
          r_s2_opcode   <= r_s1_opcode;
          r_s2_expected <= w_golden;
          r_s2_actual   <= r_s1_out;
        end
        // Scoring: entries still draining in HALT are counted as usual.
        if (r_s2_valid && r_s2_match && !(&r_pass_cnt))
          r_pass_cnt <= r_pass_cnt + CNT_ONE;
        if (w_s2_fail) begin
          if (!(&r_fail_cnt)) r_fail_cnt <= r_fail_cnt + CNT_ONE;
          r_err_flag <= 1'b1;
          if (!r_err_flag) begin
            r_ff_opcode   <= r_s2_opcode;
            r_ff_expected <= r_s2_expected;
            r_ff_actual   <= r_s2_actual;
          end
          if (stop_on_fail && r_state == ST_RUN) r_state <= ST_HALT;
        end
      end
    end
  end

  assign pass_cnt    = r_pass_cnt;
  assign fail_cnt    = r_fail_cnt;
  assign err_flag    = r_err_flag;
  assign halted      = (r_state == ST_HALT);
  assign ff_opcode   = r_ff_opcode;
  assign ff_expected = r_ff_expected;
  assign ff_actual   = r_ff_actual;

`ifdef ALU_CHK_LOG_EN
  logic [2:0]        r_log_opcode   [4];
  logic [DATA_W-1:0] r_log_expected [4];
  logic [DATA_W-1:0] r_log_actual   [4];
  logic [1:0]        r_log_wr_ptr, r_log_rd_ptr;
  logic [2:0]        r_log_count;
  logic              r_log_ovf;
  logic              w_log_full, w_log_pop, w_log_push;

  assign log_empty  = (r_log_count == 3'd0);
  assign w_log_full = (r_log_count == 3'd4);
  assign w_log_pop  = log_rd && !log_empty;
  // Popping while full frees a slot for the same-edge push.
  assign w_log_push = w_s2_fail && (!w_log_full || w_log_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_log_wr_ptr <= '0;
      r_log_rd_ptr <= '0;
      r_log_count  <= '0;
      r_log_ovf    <= 1'b0;
    end else if (clear) begin
      r_log_wr_ptr <= '0;
      r_log_rd_ptr <= '0;
      r_log_count  <= '0;
      r_log_ovf    <= 1'b0;
    end else begin
      if (w_log_push) r_log_wr_ptr <= r_log_wr_ptr + 2'd1;
      if (w_log_pop)  r_log_rd_ptr <= r_log_rd_ptr + 2'd1;
      if (w_log_push && !w_log_pop)      r_log_count <= r_log_count + 3'd1;
      else if (!w_log_push && w_log_pop) r_log_count <= r_log_count - 3'd1;
      if (w_s2_fail && !w_log_push) r_log_ovf <= 1'b1;
    end
  end

  // NOTE: log storage has no reset; validity is tracked by the pointers and
  // count, and the outputs are gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_log_push && !clear) begin
      r_log_opcode[r_log_wr_ptr]   <= r_s2_opcode;
      r_log_expected[r_log_wr_ptr] <= r_s2_expected;
      r_log_actual[r_log_wr_ptr]   <= r_s2_actual;
    end
  end

  assign log_ovf      = r_log_ovf;
  assign log_opcode   = log_empty ? '0 : r_log_opcode[r_log_rd_ptr];
  assign log_expected = log_empty ? '0 : r_log_expected[r_log_rd_ptr];
  assign log_actual   = log_empty ? '0 : r_log_actual[r_log_rd_ptr];
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// -----------------------------------------------------------------------------
// tb_alu_result_checker
//
// Directed self-checking bench for alu_result_checker (DATA_W=32, CNT_W=4 so
// counter saturation is reachable). Inputs change and outputs are sampled 1ns
// after each rising edge. Log FIFO scenario is built when ALU_CHK_LOG_EN is set.
// -----------------------------------------------------------------------------
module tb_alu_result_checker;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              obs_valid;
  logic              obs_ready;
  logic [2:0]        obs_opcode;
  logic [DATA_W-1:0] obs_in1, obs_in2, obs_out;
  logic              stop_on_fail;
  logic              clear;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;
  logic              err_flag, halted;
  logic [2:0]        ff_opcode;
  logic [DATA_W-1:0] ff_expected, ff_actual;
`ifdef ALU_CHK_LOG_EN
  logic              log_rd;
  logic              log_empty, log_ovf;
  logic [2:0]        log_opcode;
  logic [DATA_W-1:0] log_expected, log_actual;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .obs_valid(obs_valid), .obs_ready(obs_ready),
    .obs_opcode(obs_opcode), .obs_in1(obs_in1), .obs_in2(obs_in2), .obs_out(obs_out),
    .stop_on_fail(stop_on_fail), .clear(clear),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag), .halted(halted),
    .ff_opcode(ff_opcode), .ff_expected(ff_expected), .ff_actual(ff_actual)
`ifdef ALU_CHK_LOG_EN
    ,
    .log_rd(log_rd), .log_empty(log_empty), .log_ovf(log_ovf),
    .log_opcode(log_opcode), .log_expected(log_expected), .log_actual(log_actual)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] o);
    obs_valid  = 1'b1;
    obs_opcode = op;
    obs_in1    = a;
    obs_in2    = b;
    obs_out    = o;
  endtask

  task automatic idle(input int n);
    obs_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    obs_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", obs_ready); end
    n_cmp++; if (pass_cnt !== 4'd0 || fail_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", pass_cnt, fail_cnt); end
    n_cmp++; if (err_flag !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL reset_flags: err %b halted %b want 0 0", err_flag, halted); end
    n_cmp++; if (ff_opcode !== 3'd0 || ff_expected !== 32'd0 || ff_actual !== 32'd0) begin n_err++; $display("FAIL reset_ff: got %0d %0d %0d want 0 0 0", ff_opcode, ff_expected, ff_actual); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset: got %b want 1", obs_ready); end
  endtask

  task automatic test_pass_sweep();
    logic [31:0] outs [8];
    outs = '{32'd3000, 32'd1000, 32'd4294965295, 32'd960, 32'd2040, 32'd1080, 32'd4000, 32'd1000};
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 32'd2000, 32'd1000, outs[i]);
      step();
    end
    idle(1);
    n_cmp++; if (pass_cnt !== 4'd7) begin n_err++; $display("FAIL sweep_latency: got %0d want 7", pass_cnt); end
    idle(1);
    n_cmp++; if (pass_cnt !== 4'd8) begin n_err++; $display("FAIL sweep_pass: got %0d want 8", pass_cnt); end
    n_cmp++; if (fail_cnt !== 4'd0 || err_flag !== 1'b0) begin n_err++; $display("FAIL sweep_fail: got %0d err %b want 0 0", fail_cnt, err_flag); end
  endtask

  task automatic test_single_mismatch();
    int not_ready = 0;
    do_clear();
    stop_on_fail = 1'b0;
    drive(3'b011, 32'd2000, 32'd1000, 32'd961);   step();
    drive(3'b000, 32'd2000, 32'd1000, 32'd3000);  step();
    drive(3'b100, 32'd2000, 32'd1000, 32'd2040);  step();
    if (obs_ready !== 1'b1) not_ready++;
    drive(3'b111, 32'd2000, 32'd1000, 32'd1000);  step();
    if (obs_ready !== 1'b1) not_ready++;
    idle(2);
    if (obs_ready !== 1'b1) not_ready++;
    n_cmp++; if (not_ready != 0) begin n_err++; $display("FAIL mm_ready: dropped %0d times want 0", not_ready); end
    n_cmp++; if (fail_cnt !== 4'd1 || pass_cnt !== 4'd3) begin n_err++; $display("FAIL mm_counts: got %0d/%0d want 3/1", pass_cnt, fail_cnt); end
    n_cmp++; if (ff_opcode !== 3'b011 || ff_expected !== 32'd960 || ff_actual !== 32'd961) begin n_err++; $display("FAIL mm_ff: got %0d %0d %0d want 3 960 961", ff_opcode, ff_expected, ff_actual); end
    n_cmp++; if (err_flag !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL mm_flags: err %b halted %b want 1 0", err_flag, halted); end
  endtask

  task automatic test_halt();
    do_clear();
    stop_on_fail = 1'b1;
    drive(3'b000, 32'd2000, 32'd1000, 32'd2999);  step();
    drive(3'b000, 32'd2000, 32'd1000, 32'd3000);  step();
    idle(2);
    n_cmp++; if (halted !== 1'b1 || obs_ready !== 1'b0) begin n_err++; $display("FAIL halt_state: halted %b ready %b want 1 0", halted, obs_ready); end
    n_cmp++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd1) begin n_err++; $display("FAIL halt_trailing: got %0d/%0d want 1/1", pass_cnt, fail_cnt); end
    stop_on_fail = 1'b0;
    drive(3'b000, 32'd1, 32'd1, 32'd5);
    step(); step(); step();
    idle(3);
    n_cmp++; if (pass_cnt !== 4'd1 || fail_cnt !== 4'd1 || halted !== 1'b1) begin n_err++; $display("FAIL halt_ignore: got %0d/%0d halted %b want 1/1 1", pass_cnt, fail_cnt, halted); end
    clear = 1'b1;
    #1;
    n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL clear_ready: got %b want 0", obs_ready); end
    step();
    clear = 1'b0;
    #1;
    n_cmp++; if (pass_cnt !== 4'd0 || fail_cnt !== 4'd0 || halted !== 1'b0 || err_flag !== 1'b0) begin n_err++; $display("FAIL clear_state: got %0d/%0d halted %b err %b want 0/0 0 0", pass_cnt, fail_cnt, halted, err_flag); end
    n_cmp++; if (ff_opcode !== 3'd0 || ff_expected !== 32'd0 || ff_actual !== 32'd0 || obs_ready !== 1'b1) begin n_err++; $display("FAIL clear_ff: got %0d %0d %0d ready %b want 0 0 0 1", ff_opcode, ff_expected, ff_actual, obs_ready); end
  endtask

  task automatic test_clear_flush();
    do_clear();
    drive(3'b000, 32'd1, 32'd2, 32'd3);  step();
    drive(3'b000, 32'd1, 32'd2, 32'd9);  step();
    do_clear();
    idle(3);
    n_cmp++; if (pass_cnt !== 4'd0 || fail_cnt !== 4'd0 || err_flag !== 1'b0) begin n_err++; $display("FAIL clear_flush: got %0d/%0d err %b want 0/0 0", pass_cnt, fail_cnt, err_flag); end
  endtask

  task automatic test_boundary();
    do_clear();
    drive(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);  step();
    drive(3'b111, 32'h80000001, 32'h0, 32'h40000000);         step();
    drive(3'b110, 32'h80000001, 32'h0, 32'h00000002);         step();
    drive(3'b001, 32'h0, 32'h1, 32'hFFFFFFFF);                step();
    idle(2);
    n_cmp++; if (pass_cnt !== 4'd4 || fail_cnt !== 4'd0) begin n_err++; $display("FAIL boundary: got %0d/%0d want 4/0", pass_cnt, fail_cnt); end
  endtask

  task automatic test_saturation();
    do_clear();
    stop_on_fail = 1'b0;
    drive(3'b101, 32'd5, 32'd3, 32'd0);  step();
    for (int i = 0; i < 19; i++) begin
      drive(3'b000, 32'd0, 32'd0, 32'd1);
      step();
    end
    drive(3'b000, 32'd0, 32'd0, 32'd0);  step();
    idle(2);
    n_cmp++; if (fail_cnt !== 4'd15) begin n_err++; $display("FAIL sat_fail: got %0d want 15", fail_cnt); end
    n_cmp++; if (pass_cnt !== 4'd1) begin n_err++; $display("FAIL sat_pass: got %0d want 1", pass_cnt); end
    n_cmp++; if (ff_opcode !== 3'b101 || ff_expected !== 32'd6 || ff_actual !== 32'd0) begin n_err++; $display("FAIL sat_ff: got %0d %0d %0d want 5 6 0", ff_opcode, ff_expected, ff_actual); end
  endtask

  task automatic test_reset_midflight();
    do_clear();
    drive(3'b000, 32'd2, 32'd2, 32'd4);  step();
    drive(3'b000, 32'd2, 32'd2, 32'd7);  step();
    obs_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    idle(3);
    n_cmp++; if (pass_cnt !== 4'd0 || fail_cnt !== 4'd0 || err_flag !== 1'b0) begin n_err++; $display("FAIL reset_midflight: got %0d/%0d err %b want 0/0 0", pass_cnt, fail_cnt, err_flag); end
    n_cmp++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL reset_midflight_ready: got %b want 1", obs_ready); end
  endtask

`ifdef ALU_CHK_LOG_EN
  task automatic test_log();
    logic [31:0] exps [5];
    exps = '{32'd3000, 32'd1000, 32'd4294965295, 32'd960, 32'd2040};
    do_clear();
    stop_on_fail = 1'b0;
    log_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3'(i), 32'd2000, 32'd1000, 32'd0);
      step();
    end
    idle(2);
    n_cmp++; if (log_ovf !== 1'b1 || log_empty !== 1'b0) begin n_err++; $display("FAIL log_ovf: ovf %b empty %b want 1 0", log_ovf, log_empty); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (log_opcode !== 3'(i) || log_expected !== exps[i] || log_actual !== 32'd0) begin
        n_err++;
        $display("FAIL log_entry%0d: got %0d %0d %0d want %0d %0d 0", i, log_opcode, log_expected, log_actual, i, exps[i]);
      end
      log_rd = 1'b1;
      step();
      log_rd = 1'b0;
    end
    n_cmp++; if (log_empty !== 1'b1) begin n_err++; $display("FAIL log_empty: got %b want 1", log_empty); end
    do_clear();
    #1;
    n_cmp++; if (log_ovf !== 1'b0) begin n_err++; $display("FAIL log_clear: ovf %b want 0", log_ovf); end
  endtask
`endif

  initial begin
    obs_valid    = 1'b0;
    obs_opcode   = '0;
    obs_in1      = '0;
    obs_in2      = '0;
    obs_out      = '0;
    stop_on_fail = 1'b0;
    clear        = 1'b0;
`ifdef ALU_CHK_LOG_EN
    log_rd       = 1'b0;
`endif
    test_reset();
    test_pass_sweep();
    test_single_mismatch();
    test_halt();
    test_clear_flush();
    test_boundary();
    test_saturation();
    test_reset_midflight();
`ifdef ALU_CHK_LOG_EN
    test_log();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Hardware response checker at the receiving end of the ALU test interface.
- Accepts observed transactions (opcode, in1, in2, out) over a valid/ready handshake and recomputes the expected result with an internal golden model.
- Compares the expected and observed results, keeps pass/fail counts, and captures the first mismatch.
- Can optionally halt intake on the first failure. Sits beside the ALU in self-checking simulation and on-chip BIST.

Parameters:
- DATA_W, 32, operand/result width
- CNT_W, 16, width of pass/fail counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- obs_valid  in  1  observed transaction valid
- obs_ready  out  1  checker can accept
- obs_opcode  in  3  ALU opcode applied
- obs_in1  in  DATA_W  operand A applied
- obs_in2  in  DATA_W  operand B applied
- obs_out  in  DATA_W  ALU output observed
- stop_on_fail  in  1  1 = enter HALT on first mismatch
- clear  in  1  synchronous clear of counters/capture/state
- pass_cnt  out  CNT_W  matching transactions
- fail_cnt  out  CNT_W  mismatching transactions
- err_flag  out  1  sticky, at least one mismatch since clear/reset
- halted  out  1  high in HALT state
- ff_opcode  out  3  first-fail opcode
- ff_expected  out  DATA_W  first-fail golden value
- ff_actual  out  DATA_W  first-fail observed value

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Reset values:
  - all counters, ff_* and err_flag are 0
  - state is RUN, halted=0, pipeline empty
  - obs_ready=1 from the first edge after deassertion
- Transfer: a transaction is accepted on a rising edge with obs_valid&&obs_ready. Inputs are ignored when obs_valid=0.
- Pipeline:
  - S1 registers the accepted fields.
  - S2 computes the golden value from the S1 registers and compares it with obs_out.
  - The counters, err_flag and ff_* registers update on the S2 edge.
  - A transaction accepted at edge N is visible on the outputs after edge N+2. Throughput is 1 per cycle.
- Golden model (modulo 2^DATA_W):
  - 000 in1+in2
  - 001 in1-in2
  - 010 ~in1
  - 011 in1&in2
  - 100 in1|in2
  - 101 in1^in2
  - 110 in1<<1, LSB 0
  - 111 in1>>1, logical, MSB 0
- Counters: saturate at all-ones and never wrap.
- First-fail capture: ff_* load only on a mismatch while err_flag=0, so the later mismatches do not overwrite them. err_flag sets with the first mismatch.
- FSM, RUN:
  - obs_ready=1 unless clear=1.
  - A mismatch in S2 with stop_on_fail=1 moves the state to HALT on that edge.
- FSM, HALT:
  - obs_ready=0, halted=1.
  - A transaction already in S1 when the halt occurs is still checked and counted.
  - The state leaves HALT only via clear or reset.
- clear: highest priority and synchronous.
  - obs_ready=0 while clear=1, so a simultaneous valid is not accepted.
  - On the edge: counters, ff_* and err_flag go to 0, S1/S2 are flushed without counting, and the state goes to RUN.
- stop_on_fail is sampled at S2 evaluation. Changing it while in HALT has no effect.
- Reset mid-transaction: in-flight entries are discarded and nothing is counted.

Optional Feature:
- Macro: ALU_CHK_LOG_EN.
- When defined, adds a 4-entry mismatch log FIFO with these ports:
  - log_rd  in  1
  - log_empty  out  1
  - log_ovf  out  1, sticky
  - log_opcode  out  3
  - log_expected  out  DATA_W
  - log_actual  out  DATA_W
- Log push and read:
  - Every S2 mismatch pushes one entry.
  - The head is shown combinationally when log_empty=0. log_rd pops the head on the edge, and is ignored when empty.
  - Simultaneous push and pop while full: both occur, with no overflow.
  - A push while full without a pop drops the entry and sets log_ovf.
- Clearing: clear and reset empty the FIFO and clear log_ovf.
- When not defined, these ports and the logic do not exist, and the behaviour is otherwise identical.

Test Plan:
- Pass sweep: in1=2000, in2=1000, opcodes 000..111 with correct outs 3000, 1000, 4294965295, 960, 2040, 1080, 4000, 1000, back-to-back -> pass_cnt=8 two cycles after the last accept, fail_cnt=0, err_flag=0.
- Single mismatch: opcode 011, out=961 (expected 960), stop_on_fail=0, then 3 correct transactions -> fail_cnt=1, pass_cnt=3, ff_opcode=011, ff_expected=960, ff_actual=961, obs_ready stays 1.
- Halt: stop_on_fail=1, mismatch on opcode 000 (out=2999) followed immediately by a correct transaction -> halted=1, obs_ready=0; the trailing transaction is counted (pass_cnt=1); further obs_valid is ignored. Pulse clear -> all counts 0, halted=0.
- Wrap/boundary: opcode 000 with in1=in2=32'hFFFFFFFF, out=32'hFFFFFFFE -> pass. Opcode 111 with in1=32'h80000001, out=32'h40000000 -> pass.
- Saturation, with CNT_W=4: 20 mismatches -> fail_cnt=15, ff_* hold the first mismatch.
- With ALU_CHK_LOG_EN: 5 mismatches, no reads -> log_ovf=1 and 4 entries in order. Pop all with log_rd -> log_empty=1.
